// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and the hazard controller.
// The master side (pipeline) supplies register numbers, hazard indications and
// mem_wait; the slave side (hazard_ctrl) returns latch enables, flushes,
// forwarding selects, the freeze-timeout flag and the performance counters.
interface hazard_ctrl_if;
  // Hazard and forwarding inputs seen by the controller
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic        ex_memread;
  logic [4:0]  mem_dest;
  logic        mem_regwrite;
  logic        mem_branch;
  logic        mem_zero;
  logic [4:0]  wb_dest;
  logic        wb_regwrite;
  logic        mem_wait;

  // Pipeline controls returned by the controller
  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        exmem_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pc_src;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        freeze_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] freeze_cnt;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_dest, ex_memread,
           mem_dest, mem_regwrite, mem_branch, mem_zero,
           wb_dest, wb_regwrite, mem_wait,
    input  pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
           ifid_flush, idex_flush, exmem_flush, pc_src, fwd_a, fwd_b,
           freeze_timeout, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_dest, ex_memread,
           mem_dest, mem_regwrite, mem_branch, mem_zero,
           wb_dest, wb_regwrite, mem_wait,
    output pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
           ifid_flush, idex_flush, exmem_flush, pc_src, fwd_a, fwd_b,
           freeze_timeout, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage MIPS hazard controller.
// Sequences the pipeline latches through RUN / FREEZE / LDSTALL / FLUSH,
// drives the EX-stage forwarding selects, and flags data-memory freezes that
// last FREEZE_MAX consecutive cycles (sticky until rst).
// Optional build macro: HAZARD_PERF_CNT_EN enables the saturating
// stall/flush/freeze performance counters; without it they read 0.
module hazard_ctrl #(
  parameter int unsigned FREEZE_MAX = 255
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FREEZE  = 2'd1,
    S_LDSTALL = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  localparam int unsigned WD_BITS = $clog2(FREEZE_MAX + 1);
  localparam int unsigned WD_W    = (WD_BITS > 8) ? WD_BITS : 8;
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(FREEZE_MAX);
  localparam logic [WD_W:0]   WD_LIM = (WD_W + 1)'(FREEZE_MAX);

  state_t state, state_next;

  logic br_taken;
  logic load_use;

  logic c_pc_write, c_ifid_write, c_idex_write, c_exmem_write;
  logic c_idex_bubble, c_flush, c_pc_src;

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Register $0 is hard-wired, so a write to it is never a real producer.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_rw,
    input logic [4:0] mem_d,
    input logic       wb_rw,
    input logic [4:0] wb_d
  );
    if (mem_rw && (mem_d != 5'd0) && (mem_d == src))
      return 2'b10;
    else if (wb_rw && (wb_d != 5'd0) && (wb_d == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Hazard conditions derived from the EX and EX/MEM latches.
  always_comb begin
    br_taken = hz.mem_branch & hz.mem_zero;
    load_use = hz.ex_memread & (hz.ex_dest != 5'd0) &
               ((hz.ex_dest == hz.id_rs) | (hz.ex_dest == hz.id_rt));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_RUN;
    else     state <= state_next;
  end

  // Next-state and latch controls: freeze > branch flush > load-use stall > run.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_next    = state;
    c_pc_write    = 1'b0;
    c_ifid_write  = 1'b0;
    c_idex_write  = 1'b0;
    c_exmem_write = 1'b0;
    c_idex_bubble = 1'b0;
    c_flush       = 1'b0;
    c_pc_src      = 1'b0;
    if (rst) begin
      state_next = S_RUN;
    end else if (hz.mem_wait) begin
      state_next = S_FREEZE;
    end else if (br_taken && (state != S_FLUSH)) begin
      c_pc_write    = 1'b1;
      c_ifid_write  = 1'b1;
      c_idex_write  = 1'b1;
      c_exmem_write = 1'b1;
      c_flush       = 1'b1;
      c_pc_src      = 1'b1;
      state_next    = S_FLUSH;
    end else if (load_use && (state != S_LDSTALL)) begin
      c_idex_write  = 1'b1;
      c_exmem_write = 1'b1;
      c_idex_bubble = 1'b1;
      state_next    = S_LDSTALL;
    end else begin
      c_pc_write    = 1'b1;
      c_ifid_write  = 1'b1;
      c_idex_write  = 1'b1;
      c_exmem_write = 1'b1;
      state_next    = S_RUN;
    end
  end

  // Freeze watchdog: counts consecutive mem_wait cycles, sets a sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!hz.mem_wait)          wd_cnt <= '0;
      else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_ONE;
      if (hz.mem_wait && (({1'b0, wd_cnt} + {1'b0, WD_ONE}) >= WD_LIM))
        timeout_q <= 1'b1;
    end
  end

  // Controls drive the latches directly; everything reads 0 while rst is high.
  assign hz.pc_write       = c_pc_write;
  assign hz.ifid_write     = c_ifid_write;
  assign hz.idex_write     = c_idex_write;
  assign hz.exmem_write    = c_exmem_write;
  assign hz.idex_bubble    = c_idex_bubble;
  assign hz.ifid_flush     = c_flush;
  assign hz.idex_flush     = c_flush;
  assign hz.exmem_flush    = c_flush;
  assign hz.pc_src         = c_pc_src;
  assign hz.fwd_a          = rst ? 2'b00 : fwd_sel(hz.ex_rs, hz.mem_regwrite, hz.mem_dest,
                                                   hz.wb_regwrite, hz.wb_dest);
  assign hz.fwd_b          = rst ? 2'b00 : fwd_sel(hz.ex_rt, hz.mem_regwrite, hz.mem_dest,
                                                   hz.wb_regwrite, hz.wb_dest);
  assign hz.freeze_timeout = timeout_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q, freeze_q;

  // Saturating performance counters, one event per cycle each.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (c_idex_bubble && (stall_q != '1))  stall_q  <= stall_q + 32'd1;
      if (c_flush && (flush_q != '1))        flush_q  <= flush_q + 32'd1;
      if (hz.mem_wait && (freeze_q != '1))   freeze_q <= freeze_q + 32'd1;
    end
  end

  assign hz.stall_cnt  = rst ? 32'd0 : stall_q;
  assign hz.flush_cnt  = rst ? 32'd0 : flush_q;
  assign hz.freeze_cnt = rst ? 32'd0 : freeze_q;
`else
  assign hz.stall_cnt  = 32'd0;
  assign hz.flush_cnt  = 32'd0;
  assign hz.freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl plus hand
// sequences for reset mid-operation, the freeze watchdog and the counters.
module tb_hazard_ctrl;

  // Control vector: {pc_write, ifid_write, idex_write, exmem_write,
  //                  idex_bubble, ifid_flush, idex_flush, exmem_flush, pc_src}
  localparam logic [8:0] C_RUN    = 9'b1111_0_000_0;
  localparam logic [8:0] C_STALL  = 9'b0011_1_000_0;
  localparam logic [8:0] C_FLUSH  = 9'b1111_0_111_1;
  localparam logic [8:0] C_FREEZE = 9'b0000_0_000_0;
  localparam logic [8:0] C_ZERO   = 9'b0000_0_000_0;

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt;
    logic       ex_memread;
    logic [4:0] ex_dest;
    logic       mem_branch, mem_zero, mem_wait;
    logic [4:0] ex_rs, ex_rt;
    logic       mem_regwrite;
    logic [4:0] mem_dest;
    logic       wb_regwrite;
    logic [4:0] wb_dest;
    logic [8:0] exp_ctrl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  hazard_ctrl_if hz_if();

  hazard_ctrl #(.FREEZE_MAX(255)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input string n,
    input logic [4:0] id_rs, input logic [4:0] id_rt,
    input logic ex_memread, input logic [4:0] ex_dest,
    input logic mem_branch, input logic mem_zero, input logic mem_wait,
    input logic [4:0] ex_rs, input logic [4:0] ex_rt,
    input logic mem_regwrite, input logic [4:0] mem_dest,
    input logic wb_regwrite, input logic [4:0] wb_dest,
    input logic [8:0] exp_ctrl, input logic [1:0] exp_fa, input logic [1:0] exp_fb
  );
    vec_t v;
    v.name = n;
    v.id_rs = id_rs; v.id_rt = id_rt;
    v.ex_memread = ex_memread; v.ex_dest = ex_dest;
    v.mem_branch = mem_branch; v.mem_zero = mem_zero; v.mem_wait = mem_wait;
    v.ex_rs = ex_rs; v.ex_rt = ex_rt;
    v.mem_regwrite = mem_regwrite; v.mem_dest = mem_dest;
    v.wb_regwrite = wb_regwrite; v.wb_dest = wb_dest;
    v.exp_ctrl = exp_ctrl; v.exp_fa = exp_fa; v.exp_fb = exp_fb;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz_if.id_rs = v.id_rs;           hz_if.id_rt = v.id_rt;
    hz_if.ex_memread = v.ex_memread; hz_if.ex_dest = v.ex_dest;
    hz_if.mem_branch = v.mem_branch; hz_if.mem_zero = v.mem_zero;
    hz_if.mem_wait = v.mem_wait;
    hz_if.ex_rs = v.ex_rs;           hz_if.ex_rt = v.ex_rt;
    hz_if.mem_regwrite = v.mem_regwrite; hz_if.mem_dest = v.mem_dest;
    hz_if.wb_regwrite = v.wb_regwrite;   hz_if.wb_dest = v.wb_dest;
  endtask

  task automatic clear_inputs();
    apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_now();
    return {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_write, hz_if.exmem_write,
            hz_if.idex_bubble, hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_flush,
            hz_if.pc_src};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : timeout_guard
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int exp_stall, exp_flush, exp_freeze;

    //               name        rs rt mr exd mb mz mw exrs exrt mrw md wrw wd ctrl      fa     fb
    vecs.push_back(mk("idle0",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("lu_rt",     0, 5, 1, 5, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_STALL,  2'b00, 2'b00));
    vecs.push_back(mk("lu_mask",   0, 5, 1, 5, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("idle1",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("lu_rs",     9, 0, 1, 9, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_STALL,  2'b00, 2'b00));
    vecs.push_back(mk("idle2",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("lu_r0",     0, 0, 1, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("no_load",   0, 5, 0, 5, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("br",        0, 0, 0, 0, 1, 1, 0,  0,  0,  0, 0,  0, 0, C_FLUSH,  2'b00, 2'b00));
    vecs.push_back(mk("br_mask",   0, 0, 0, 0, 1, 1, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("idle3",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("br_nz",     0, 0, 0, 0, 1, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("br_lu",     0, 5, 1, 5, 1, 1, 0,  0,  0,  0, 0,  0, 0, C_FLUSH,  2'b00, 2'b00));
    vecs.push_back(mk("lu_aft_fl", 0, 5, 1, 5, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_STALL,  2'b00, 2'b00));
    vecs.push_back(mk("idle4",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("fwd_mem",   0, 0, 0, 0, 0, 0, 0,  7,  0,  1, 7,  1, 7, C_RUN,    2'b10, 2'b00));
    vecs.push_back(mk("fwd_wb",    0, 0, 0, 0, 0, 0, 0,  7,  0,  0, 7,  1, 7, C_RUN,    2'b01, 2'b00));
    vecs.push_back(mk("fwd_r0",    0, 0, 0, 0, 0, 0, 0,  0,  0,  1, 0,  1, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("fwd_mix",   0, 0, 0, 0, 0, 0, 0,  4,  3,  1, 3,  1, 4, C_RUN,    2'b01, 2'b10));
    vecs.push_back(mk("fwd_wb2",   0, 0, 0, 0, 0, 0, 0, 12, 12,  0,12,  1,12, C_RUN,    2'b01, 2'b01));
    vecs.push_back(mk("fwd_nowr",  0, 0, 0, 0, 0, 0, 0,  5,  6,  1, 6,  0, 5, C_RUN,    2'b00, 2'b10));
    vecs.push_back(mk("frz_br0",   0, 0, 0, 0, 1, 1, 1,  0,  0,  0, 0,  0, 0, C_FREEZE, 2'b00, 2'b00));
    vecs.push_back(mk("frz_br1",   0, 0, 0, 0, 1, 1, 1,  7,  0,  1, 7,  0, 0, C_FREEZE, 2'b10, 2'b00));
    vecs.push_back(mk("frz_br2",   0, 0, 0, 0, 1, 1, 1,  0,  0,  0, 0,  0, 0, C_FREEZE, 2'b00, 2'b00));
    vecs.push_back(mk("frz_rel",   0, 0, 0, 0, 1, 1, 0,  0,  0,  0, 0,  0, 0, C_FLUSH,  2'b00, 2'b00));
    vecs.push_back(mk("idle5",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));
    vecs.push_back(mk("frz_lu",    0, 5, 1, 5, 0, 0, 1,  0,  0,  0, 0,  0, 0, C_FREEZE, 2'b00, 2'b00));
    vecs.push_back(mk("lu_rel",    0, 5, 1, 5, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_STALL,  2'b00, 2'b00));
    vecs.push_back(mk("idle6",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 0, C_RUN,    2'b00, 2'b00));

    // Reset: every output must read 0 even with hazards and matches present.
    rst = 1'b1;
    apply(mk("rst_in", 0, 5, 1, 5, 1, 1, 1, 7, 7, 1, 7, 1, 7, C_ZERO, 2'b00, 2'b00));
    #1;
    check("rst_ctrl",    32'(ctrl_now()), 32'(C_ZERO));
    check("rst_fwd",     {28'd0, hz_if.fwd_a, hz_if.fwd_b}, 32'd0);
    check("rst_timeout", {31'd0, hz_if.freeze_timeout}, 32'd0);
    check("rst_cnts",    hz_if.stall_cnt | hz_if.flush_cnt | hz_if.freeze_cnt, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    clear_inputs();

    // Table-driven cycle-by-cycle vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("%s.ctrl", vecs[i].name), 32'(ctrl_now()), 32'(vecs[i].exp_ctrl));
      check($sformatf("%s.fwd_a", vecs[i].name), 32'(hz_if.fwd_a), 32'(vecs[i].exp_fa));
      check($sformatf("%s.fwd_b", vecs[i].name), 32'(hz_if.fwd_b), 32'(vecs[i].exp_fb));
      next_cycle();
    end
    clear_inputs();
    #1;

`ifdef HAZARD_PERF_CNT_EN
    exp_stall = 4; exp_flush = 3; exp_freeze = 4;
`else
    exp_stall = 0; exp_flush = 0; exp_freeze = 0;
`endif
    check("stall_cnt",  hz_if.stall_cnt,  32'(exp_stall));
    check("flush_cnt",  hz_if.flush_cnt,  32'(exp_flush));
    check("freeze_cnt", hz_if.freeze_cnt, 32'(exp_freeze));

    // Reset pulse clears counters.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("cnt_after_rst", hz_if.stall_cnt | hz_if.flush_cnt | hz_if.freeze_cnt, 32'd0);

    // Reset while in LDSTALL: the stall mask must not survive reset.
    apply(mk("lu", 0, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00));
    #1;
    check("midrst_lu_stall", 32'(ctrl_now()), 32'(C_STALL));
    next_cycle();
    check("midrst_lu_mask", 32'(ctrl_now()), 32'(C_RUN));
    rst = 1'b1;
    #1;
    check("midrst_lu_zero", 32'(ctrl_now()), 32'(C_ZERO));
    next_cycle();
    rst = 1'b0;
    #1;
    check("midrst_lu_again", 32'(ctrl_now()), 32'(C_STALL));
    clear_inputs();
    next_cycle();

    // Reset while in FLUSH: the branch mask must not survive reset.
    apply(mk("br", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, 2'b00, 2'b00));
    #1;
    check("midrst_br_flush", 32'(ctrl_now()), 32'(C_FLUSH));
    next_cycle();
    check("midrst_br_mask", 32'(ctrl_now()), 32'(C_RUN));
    rst = 1'b1;
    #1;
    check("midrst_br_zero", 32'(ctrl_now()), 32'(C_ZERO));
    next_cycle();
    rst = 1'b0;
    #1;
    check("midrst_br_again", 32'(ctrl_now()), 32'(C_FLUSH));
    clear_inputs();
    next_cycle();

    // Watchdog: an interrupted freeze must not accumulate.
    hz_if.mem_wait = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    hz_if.mem_wait = 1'b0;
    next_cycle();
    hz_if.mem_wait = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("wd_interrupted", {31'd0, hz_if.freeze_timeout}, 32'd0);
    hz_if.mem_wait = 1'b0;
    next_cycle();

    // Watchdog: 254 consecutive cycles is below threshold, 255 trips it.
    hz_if.mem_wait = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    check("wd_254", {31'd0, hz_if.freeze_timeout}, 32'd0);
    next_cycle();
    check("wd_255", {31'd0, hz_if.freeze_timeout}, 32'd1);
    hz_if.mem_wait = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("wd_sticky", {31'd0, hz_if.freeze_timeout}, 32'd1);
    check("wd_run_after", 32'(ctrl_now()), 32'(C_RUN));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("wd_cleared", {31'd0, hz_if.freeze_timeout}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
